fcvt_arbiter: RTL and testbench

- Shares one ftoi and one itof conversion datapath between NREQ requesters, e.g. the integer pipeline and the FP pipeline of the core.
- Round-robin arbitration, a two-stage pipeline, and per-requester valid/ready handshakes on both the request and response sides.
- Sits between the core issue logic and the FPU conversion units. It instantiates both combinational converters internally and registers around them.

---
 rtl/fcvt_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fcvt_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_arbiter.sv
// rtl/fcvt_arbiter.sv - round-robin arbiter sharing one ftoi/itof datapath between NREQ requesters
module fcvt_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_op,
    input  logic [32*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_sat
);

    logic            s1_v;
    logic            s1_op;
    logic [31:0]     s1_data;
    logic [IDW-1:0]  s1_own;

    logic            s2_v;
    logic [31:0]     s2_data;
    logic            s2_sat;
    logic [IDW-1:0]  s2_own;

    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  rr_next;

    logic            own_ready;
    logic            stall;
    logic            s1_accept;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_op;
    logic [31:0]     gnt_data;
    logic [NREQ-1:0] gnt_vec;

    logic [31:0]     conv_data;
    logic            conv_sat;

    // Result is {sat, data}; magnitude rounds half away from zero via floor(2|x|)+1 >> 1.
    function automatic logic [32:0] f2i(input logic [31:0] f);
        logic        sgn;
        logic [7:0]  e;
        logic [23:0] mant;
        logic [32:0] twice;
        logic [31:0] mag;
        logic [31:0] res;
        logic        sat;
        sgn   = f[31];
        e     = f[30:23];
        mant  = {1'b1, f[22:0]};
        twice = '0;
        mag   = '0;
        res   = '0;
        sat   = 1'b0;
        if (e >= 8'd158) begin
            sat = 1'b1;
            res = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (e >= 8'd126) begin
            if (e >= 8'd149)
                twice = {9'd0, mant} << (e - 8'd149);
            else
                twice = {9'd0, mant} >> (8'd149 - e);
            mag = 32'((twice + 33'd1) >> 1);
            res = sgn ? -mag : mag;
        end
        return {sat, res};
    endfunction

    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        sgn;
        logic [31:0] mag;
        logic [4:0]  p;
        logic [31:0] norm;
        logic        rnd;
        logic [30:0] body;
        sgn = x[31];
        mag = sgn ? -x : x;
        p   = '0;
        for (int k = 0; k < 32; k++) begin
            if (mag[k])
                p = 5'(k);
        end
        norm = mag << (5'd31 - p);
        rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
        // A mantissa carry-out ripples into the exponent field, which is the correct renormalisation.
        body = {8'd127 + {3'd0, p}, norm[30:8]} + {30'd0, rnd};
        if (x == 32'd0)
            return 32'd0;
        return {sgn, body};
    endfunction

    always_comb begin
        conv_data = '0;
        conv_sat  = 1'b0;
        if (s1_op) begin
            conv_data = i2f(s1_data);
        end else begin
            {conv_sat, conv_data} = f2i(s1_data);
        end
    end

    always_comb begin
        own_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (s2_own == IDW'(i))
                own_ready = resp_ready[i];
        end
        stall     = s2_v & ~own_ready;
        s1_accept = ~s1_v | ~stall;
    end

    // Rotating priority search starting at rr.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_op   = 1'b0;
        gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any  = 1'b1;
                gnt_idx  = IDW'(idx);
                gnt_op   = req_op[idx];
                gnt_data = req_data[32*idx +: 32];
            end
        end
        gnt_any = gnt_any & s1_accept;
        rr_next = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        gnt_vec    = '0;
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_vec[i]    = gnt_any & (gnt_idx == IDW'(i));
            resp_valid[i] = s2_v & (s2_own == IDW'(i));
        end
        req_ready = gnt_vec & {NREQ{rstn}};
    end

    assign resp_data = s2_data;
    assign resp_sat  = s2_sat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v    <= 1'b0;
            s1_op   <= 1'b0;
            s1_data <= '0;
            s1_own  <= '0;
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_sat  <= 1'b0;
            s2_own  <= '0;
            rr      <= '0;
        end else begin
            if (!stall) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_data <= conv_data;
                    s2_sat  <= conv_sat;
                    s2_own  <= s1_own;
                end
            end
            if (s1_accept) begin
                s1_v <= gnt_any;
                if (gnt_any) begin
                    s1_op   <= gnt_op;
                    s1_data <= gnt_data;
                    s1_own  <= gnt_idx;
                    rr      <= rr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fcvt_arbiter.sv
// tb/tb_fcvt_arbiter.sv - scoreboard bench for fcvt_arbiter with directed conversion vectors
module tb_fcvt_arbiter;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_data;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic        resp_sat;

    fcvt_arbiter #(.NREQ(2), .IDW(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_sat   (resp_sat)
    );

    typedef struct {
        logic        op;
        logic [31:0] data;
        logic [31:0] exp;
        logic        esat;
    } stim_t;

    typedef struct {
        logic [31:0] exp;
        logic        esat;
        int          gcyc;
        bit          lat;
    } sb_t;

    stim_t pend [2][$];
    sb_t   sbq  [2][$];
    int    glog[$];
    int    rlog_own[$];
    int    rlog_cyc[$];

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [1:0] rr_en = 2'b11;
    bit         lat_en = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic push(input int r, input logic op, input logic [31:0] d,
                        input logic [31:0] e, input logic s);
        stim_t st;
        st.op = op; st.data = d; st.exp = e; st.esat = s;
        pend[r].push_back(st);
    endtask

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic flush();
        for (int i = 0; i < 2; i++) begin
            pend[i].delete();
            sbq[i].delete();
        end
        glog.delete();
        rlog_own.delete();
        rlog_cyc.delete();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int n = 0; n < bound && !done; n++) begin
            tick();
            if (pend[0].size() == 0 && pend[1].size() == 0 &&
                sbq[0].size() == 0 && sbq[1].size() == 0)
                done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got pending work after %0d cycles expected idle", bound);
        end
    endtask

    // Driver: presents queued stimulus and records grants into the scoreboard.
    initial begin
        req_valid  = '0;
        req_op     = '0;
        req_data   = '0;
        resp_ready = '0;
        forever begin
            @(negedge clk);
            resp_ready = rr_en;
            for (int i = 0; i < 2; i++) begin
                if (pend[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_op[i]            = pend[i][0].op;
                    req_data[32*i +: 32] = pend[i][0].data;
                end else begin
                    req_valid[i]         = 1'b0;
                    req_op[i]            = 1'b0;
                    req_data[32*i +: 32] = '0;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    stim_t st;
                    sb_t   sb;
                    st = pend[i].pop_front();
                    sb.exp = st.exp; sb.esat = st.esat; sb.gcyc = cyc; sb.lat = lat_en;
                    sbq[i].push_back(sb);
                    glog.push_back(i);
                end
            end
        end
    end

    // Monitor: pops and compares on every completed response handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rstn) begin
                chk("req_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
                for (int i = 0; i < 2; i++) begin
                    if (resp_valid[i] && resp_ready[i]) begin
                        if (sbq[i].size() == 0) begin
                            chk($sformatf("unexpected_resp%0d", i), 32'd1, 32'd0);
                        end else begin
                            sb_t e;
                            e = sbq[i].pop_front();
                            chk($sformatf("resp_data%0d", i), resp_data, e.exp);
                            chk($sformatf("resp_sat%0d", i), {31'd0, resp_sat}, {31'd0, e.esat});
                            if (e.lat)
                                chk("latency", 32'(cyc - e.gcyc), 32'd2);
                            rlog_own.push_back(i);
                            rlog_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        push(0, 1'b0, 32'h3FC0_0000, 32'h0000_0002, 1'b0);
        tick();
        tick();
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_sat", {31'd0, resp_sat}, 32'd0);
        release_reset();

        push(0, 1'b0, 32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0);
        push(0, 1'b0, 32'h3ECC_CCCD, 32'h0000_0000, 1'b0);
        push(0, 1'b0, 32'h4020_0000, 32'h0000_0003, 1'b0);
        wait_idle(100);

        push(0, 1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1);
        push(0, 1'b0, 32'hCF80_0000, 32'h8000_0000, 1'b1);
        push(0, 1'b0, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1);
        wait_idle(100);

        push(1, 1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
        push(1, 1'b1, 32'h0100_0001, 32'h4B80_0000, 1'b0);
        push(1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        wait_idle(100);

        // Round-robin from a fresh reset with both requesters continuously valid.
        tick();
        rstn = 1'b0;
        flush();
        tick();
        push(0, 1'b0, 32'h3F80_0000, 32'h0000_0001, 1'b0);
        push(0, 1'b0, 32'h4000_0000, 32'h0000_0002, 1'b0);
        push(0, 1'b0, 32'h4040_0000, 32'h0000_0003, 1'b0);
        push(0, 1'b0, 32'hC080_0000, 32'hFFFF_FFFC, 1'b0);
        push(1, 1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0);
        push(1, 1'b1, 32'h0000_0002, 32'h4000_0000, 1'b0);
        push(1, 1'b1, 32'h0000_0003, 32'h4040_0000, 1'b0);
        push(1, 1'b1, 32'hFFFF_FFFC, 32'hC080_0000, 1'b0);
        release_reset();
        wait_idle(100);
        chk("rr_grant_count", 32'(glog.size()), 32'd8);
        chk("rr_resp_count", 32'(rlog_own.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < glog.size())
                chk($sformatf("rr_grant%0d", k), 32'(glog[k]), 32'(k % 2));
            if (k < rlog_own.size()) begin
                chk($sformatf("rr_resp_owner%0d", k), 32'(rlog_own[k]), 32'(k % 2));
                chk($sformatf("rr_no_bubble%0d", k), 32'(rlog_cyc[k] - rlog_cyc[0]), 32'(k));
            end
        end

        // Backpressure on requester 0.
        rr_en  = 2'b10;
        lat_en = 1'b0;
        push(0, 1'b0, 32'h3F80_0000, 32'h0000_0001, 1'b0);
        push(0, 1'b0, 32'h4000_0000, 32'h0000_0002, 1'b0);
        push(0, 1'b0, 32'h4040_0000, 32'h0000_0003, 1'b0);
        push(0, 1'b0, 32'h4080_0000, 32'h0000_0004, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                tick();
                seen = resp_valid[0];
            end
            chk("bp_resp_seen", {31'd0, seen}, 32'd1);
        end
        for (int n = 0; n < 5; n++) begin
            chk("bp_data_stable", resp_data, 32'h0000_0001);
            chk("bp_valid_held", {30'd0, resp_valid}, 32'd1);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            tick();
        end
        rr_en = 2'b11;
        wait_idle(100);
        lat_en = 1'b1;

        // Reset with both pipeline stages occupied.
        rr_en  = 2'b00;
        lat_en = 1'b0;
        push(0, 1'b0, 32'h3F80_0000, 32'h0000_0001, 1'b0);
        push(0, 1'b0, 32'h4000_0000, 32'h0000_0002, 1'b0);
        for (int n = 0; n < 4; n++) tick();
        chk("mf_pre_valid", {30'd0, resp_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("mf_async_valid", {30'd0, resp_valid}, 32'd0);
        chk("mf_async_ready", {30'd0, req_ready}, 32'd0);
        chk("mf_async_data", resp_data, 32'd0);
        flush();
        rr_en  = 2'b11;
        lat_en = 1'b1;
        push(0, 1'b0, 32'h3F80_0000, 32'h0000_0001, 1'b0);
        push(1, 1'b1, 32'h0000_0005, 32'h40A0_0000, 1'b0);
        tick();
        release_reset();
        wait_idle(100);
        chk("mf_grant_count", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) begin
            chk("mf_first_grant", 32'(glog[0]), 32'd0);
            chk("mf_second_grant", 32'(glog[1]), 32'd1);
        end
        for (int n = 0; n < 3; n++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
